psum_drain_ctrl: RTL and testbench

Hardware drain stage for the psum GLBs of the 4-cluster HMNOC array (west_0, west_1, east_0, east_1). After each `compute_done`, it waits a settle interval, then reads the `X_dim` psums of the current output row from all four clusters in lock-step. Results are streamed downstream as one 4-lane word per column over a valid/ready handshake. It replaces the manual per-row psum readback sequencing and feeds the output writer.

---
 rtl/psum_drain_ctrl.sv | 125 ++++++++++++
 tb/tb_psum_drain_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_ctrl.sv
// Drains one output row of psums from the four cluster GLBs into a 3-deep FIFO and streams 4-lane words downstream.
// First word valid 3 cycles after SETTLE ends. Reads are throttled by FIFO space plus outstanding reads, so out_ready=0 never loses data.
module psum_drain_ctrl #(
    parameter int DATA_BITWIDTH  = 16,
    parameter int ADDR_BITWIDTH  = 10,
    parameter int X_dim          = 8,
    parameter int NUM_ROWS       = 8,
    parameter int PSUM_LOAD_ADDR = 0,
    parameter int SETTLE_CYCLES  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       compute_done,
    output logic                       r_req_psum,
    output logic [ADDR_BITWIDTH-1:0]   r_addr_psum,
    input  logic [DATA_BITWIDTH-1:0]   r_data_psum_west_0,
    input  logic [DATA_BITWIDTH-1:0]   r_data_psum_west_1,
    input  logic [DATA_BITWIDTH-1:0]   r_data_psum_east_0,
    input  logic [DATA_BITWIDTH-1:0]   r_data_psum_east_1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*DATA_BITWIDTH-1:0] out_data,
    output logic [7:0]                 out_row,
    output logic [7:0]                 out_col,
    output logic                       row_done,
    output logic                       tile_done,
    output logic                       busy
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [7:0]                 row;
        logic [7:0]                 col;
        logic [4*DATA_BITWIDTH-1:0] dat;
    } fifo_ent_t;

    state_t                   r_state, w_next;
    logic                     r_cd_prev;
    logic [SW-1:0]            r_settle_cnt;
    logic [7:0]               r_row, r_col, r_req_col, r_rvalid_col;
    logic                     r_rvalid;
    fifo_ent_t                r_fifo [0:2];
    logic [1:0]               r_wr_ptr, r_rd_ptr, r_count;

    logic                     w_cd_rise, w_settle_last, w_pop, w_push, w_credit, w_issue;
    logic                     w_last_col, w_drained;
    logic [2:0]               w_occ;
    logic [ADDR_BITWIDTH-1:0] w_addr;
    fifo_ent_t                w_push_ent;

    assign w_cd_rise     = compute_done & ~r_cd_prev;
    assign w_settle_last = (r_state == SETTLE) && (r_settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign out_valid     = (r_count != 2'd0);
    assign w_pop         = out_valid & out_ready;
    assign w_push        = r_rvalid;
    // Requests on the wire and data being captured both hold a future FIFO slot; a pop frees one this cycle.
    assign w_occ         = 3'(r_count) + 3'(r_req_psum) + 3'(r_rvalid);
    assign w_credit      = w_occ < (3'd3 + 3'(w_pop));
    assign w_issue       = (w_settle_last || (r_state == READ)) && w_credit;
    assign w_last_col    = (r_col == 8'(X_dim - 1));
    assign w_drained     = (r_count == 2'd0) && !r_req_psum && !r_rvalid;
    assign w_addr        = ADDR_BITWIDTH'(PSUM_LOAD_ADDR) + ADDR_BITWIDTH'(r_row) * ADDR_BITWIDTH'(X_dim)
                         + ADDR_BITWIDTH'(r_col);
    assign w_push_ent    = {r_row, r_rvalid_col, r_data_psum_east_1, r_data_psum_east_0,
                            r_data_psum_west_1, r_data_psum_west_0};

    assign row_done  = (r_state == DRAIN) && w_drained;
    assign tile_done = row_done && (r_row == 8'(NUM_ROWS - 1));
    assign busy      = (r_state != IDLE) || out_valid;
    assign out_data  = r_fifo[r_rd_ptr].dat;
    assign out_row   = r_fifo[r_rd_ptr].row;
    assign out_col   = r_fifo[r_rd_ptr].col;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cd_rise) w_next = SETTLE;
            SETTLE:  if (w_settle_last) w_next = (w_issue && w_last_col) ? DRAIN : READ;
            READ:    if (w_issue && w_last_col) w_next = DRAIN;
            DRAIN:   if (w_drained) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cd_prev    <= 1'b0;
            r_settle_cnt <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_req_psum   <= 1'b0;
            r_addr_psum  <= '0;
            r_req_col    <= '0;
            r_rvalid     <= 1'b0;
            r_rvalid_col <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            for (int i = 0; i < 3; i++) r_fifo[i] <= '0;
        end else begin
            r_state      <= w_next;
            r_cd_prev    <= compute_done;
            r_settle_cnt <= (r_state == SETTLE) ? r_settle_cnt + SW'(1) : '0;
            r_req_psum   <= w_issue;
            if (w_issue) begin
                r_addr_psum <= w_addr;
                r_req_col   <= r_col;
                r_col       <= w_last_col ? 8'd0 : r_col + 8'd1;
            end
            // GLB data lands one cycle after the request; the column tag follows it.
            r_rvalid     <= r_req_psum;
            r_rvalid_col <= r_req_col;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_push_ent;
                r_wr_ptr         <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
            if (row_done) r_row <= tile_done ? 8'd0 : r_row + 8'd1;
        end
    end
endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Scoreboard bench for psum_drain_ctrl: stimulus pushes expected reads/words, negedge monitors pop and compare.
module tb_psum_drain_ctrl;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int XD = 8;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          compute_done = 1'b0, out_ready = 1'b1;
    logic          r_req_psum;
    logic [AW-1:0] r_addr_psum, glb_addr;
    logic [DW-1:0] d_w0, d_w1, d_e0, d_e1;
    logic          out_valid, row_done, tile_done, busy;
    logic [4*DW-1:0] out_data;
    logic [7:0]    out_row, out_col;

    logic          compute_done_w = 1'b0, out_ready_w = 1'b1;
    logic          r_req_psum_w;
    logic [AW-1:0] r_addr_psum_w, glb_addr_w;
    logic [DW-1:0] dw_w0, dw_w1, dw_e0, dw_e1;
    logic          out_valid_w, row_done_w, tile_done_w, busy_w;
    logic [4*DW-1:0] out_data_w;
    logic [7:0]    out_row_w, out_col_w;

    psum_drain_ctrl u_dut (
        .clk(clk), .reset(reset), .compute_done(compute_done),
        .r_req_psum(r_req_psum), .r_addr_psum(r_addr_psum),
        .r_data_psum_west_0(d_w0), .r_data_psum_west_1(d_w1),
        .r_data_psum_east_0(d_e0), .r_data_psum_east_1(d_e1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col),
        .row_done(row_done), .tile_done(tile_done), .busy(busy)
    );

    psum_drain_ctrl #(.PSUM_LOAD_ADDR(1020)) u_dut_wrap (
        .clk(clk), .reset(reset), .compute_done(compute_done_w),
        .r_req_psum(r_req_psum_w), .r_addr_psum(r_addr_psum_w),
        .r_data_psum_west_0(dw_w0), .r_data_psum_west_1(dw_w1),
        .r_data_psum_east_0(dw_e0), .r_data_psum_east_1(dw_e1),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
        .out_row(out_row_w), .out_col(out_col_w),
        .row_done(row_done_w), .tile_done(tile_done_w), .busy(busy_w)
    );

    function automatic logic [DW-1:0] lane(input logic [AW-1:0] a, input int k);
        return DW'(a) + DW'(k * 256);
    endfunction

    function automatic logic [4*DW-1:0] word(input logic [AW-1:0] a);
        return {lane(a, 3), lane(a, 2), lane(a, 1), lane(a, 0)};
    endfunction

    // GLB models: the address is captured with the request, data is valid the following cycle.
    always @(posedge clk) begin
        if (r_req_psum)   glb_addr   <= r_addr_psum;
        if (r_req_psum_w) glb_addr_w <= r_addr_psum_w;
    end
    assign d_w0  = lane(glb_addr, 0);
    assign d_w1  = lane(glb_addr, 1);
    assign d_e0  = lane(glb_addr, 2);
    assign d_e1  = lane(glb_addr, 3);
    assign dw_w0 = lane(glb_addr_w, 0);
    assign dw_w1 = lane(glb_addr_w, 1);
    assign dw_e0 = lane(glb_addr_w, 2);
    assign dw_e1 = lane(glb_addr_w, 3);

    typedef struct {
        logic [7:0]      row;
        logic [7:0]      col;
        logic [4*DW-1:0] dat;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] waddr_q[$];
    logic [DW-1:0] wdat_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_row = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("word_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word", {out_row, out_col, out_data}, {e.row, e.col, e.dat});
                end
            end
            if (r_req_psum) begin
                check("read_expected", 128'(addr_q.size() != 0), 128'd1);
                if (addr_q.size() != 0) check("read_addr", r_addr_psum, addr_q.pop_front());
            end
            if (r_req_psum_w) begin
                check("wrap_read_expected", 128'(waddr_q.size() != 0), 128'd1);
                if (waddr_q.size() != 0) check("wrap_read_addr", r_addr_psum_w, waddr_q.pop_front());
            end
            if (out_valid_w && out_ready_w) begin
                check("wrap_word_expected", 128'(wdat_q.size() != 0), 128'd1);
                if (wdat_q.size() != 0) check("wrap_word_lane0", out_data_w[DW-1:0], wdat_q.pop_front());
            end
        end
    end

    task automatic push_row();
        for (int c = 0; c < XD; c++) begin
            exp_t          e;
            logic [AW-1:0] a;
            a     = AW'(exp_row * XD + c);
            e.row = 8'(exp_row);
            e.col = 8'(c);
            e.dat = word(a);
            addr_q.push_back(a);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_row(input bit stall, input bit exp_tile);
        int            first_vld, done_cyc, reads;
        bit            tile_seen, tile_at_done, stable;
        logic [4*DW-1:0] head;
        first_vld = 0; done_cyc = 0; reads = 0;
        tile_seen = 0; tile_at_done = 0; stable = 1; head = '0;
        push_row();
        @(posedge clk); #1 compute_done = 1'b1;
        @(posedge clk); #1 compute_done = 1'b0;
        for (int cyc = 1; cyc < 400 && done_cyc == 0; cyc++) begin
            if (r_req_psum) reads++;
            if (tile_done) tile_seen = 1;
            if (out_valid && first_vld == 0) begin
                first_vld = cyc;
                if (stall) begin
                    out_ready = 1'b0;
                    head      = out_data;
                end
            end
            if (stall && first_vld != 0 && cyc <= first_vld + 9 && out_data !== head) stable = 0;
            if (stall && first_vld != 0 && cyc == first_vld + 10) begin
                check("stall_reads", 128'(reads), 128'd3);
                check("stall_head_stable", 128'(stable), 128'd1);
                check("stall_valid_held", 128'(out_valid), 128'd1);
                out_ready = 1'b1;
            end
            if (row_done) begin
                done_cyc     = cyc;
                tile_at_done = tile_done;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("row_done_seen", 128'(done_cyc != 0), 128'd1);
        check("tile_done", {tile_seen, tile_at_done}, {exp_tile, exp_tile});
        if (!stall) begin
            check("first_valid_cycle", 128'(first_vld), 128'd11);
            check("row_done_cycle", 128'(done_cyc), 128'd19);
        end
        exp_row = (exp_row + 1) % NR;
    endtask

    initial begin
        bit flag, found;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        flag = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (r_req_psum || r_req_psum_w) flag = 1;
        end
        check("idle_no_req", 128'(flag), 128'd0);
        check("idle_ctrl", {out_valid, row_done, tile_done, busy, r_req_psum}, 128'd0);
        check("idle_data", out_data, 128'd0);
        check("idle_rowcol", {out_row, out_col}, 128'd0);
        check("idle_addr", r_addr_psum, 128'd0);

        run_row(0, 0);
        run_row(1, 0);
        for (int r = 2; r < NR; r++) run_row(0, r == NR - 1);
        run_row(0, 0);

        for (int c = 0; c < XD; c++) begin
            logic [AW-1:0] a;
            a = AW'(1020 + c);
            waddr_q.push_back(a);
            wdat_q.push_back(lane(a, 0));
        end
        @(posedge clk); #1 compute_done_w = 1'b1;
        @(posedge clk); #1 compute_done_w = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (row_done_w) found = 1;
        end
        check("wrap_row_done", 128'(found), 128'd1);

        // Abort row 1 mid-READ, then expect row 0 to restart from column 0.
        push_row();
        @(posedge clk); #1 compute_done = 1'b1;
        @(posedge clk); #1 compute_done = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (r_req_psum && r_addr_psum == AW'(exp_row * XD + 3)) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("reset_point_found", 128'(found), 128'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || r_req_psum || busy || row_done) flag = 1;
            @(posedge clk); #1;
        end
        check("post_reset_quiet", 128'(flag), 128'd0);
        check("post_reset_rowcol", {out_row, out_col}, 128'd0);
        exp_row = 0;
        run_row(0, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", 128'(exp_q.size() + addr_q.size() + waddr_q.size() + wdat_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
